// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: fetch state encoding, NOP word, halt opcode,
// drain length and reset PC.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } fetch_state_t;

  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam logic [5:0]  HALT_OPCODE  = 6'h3F;
  localparam logic [2:0]  DRAIN_CYCLES = 3'd4;
  localparam logic [31:0] RESET_PC     = 32'h0000_0000;

  // Instruction memory is word addressed; byte offset of a target is dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
interface instruction_fetch_if;
  // No valid/ready: the memory is a combinational read, so imem_rdata is the
  // word at imem_addr in the same cycle and every cycle is a completed access.
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: sequential fetch, branch/jump redirects, stall hold and a
// halt opcode that drains the pipe for DRAIN_CYCLES before returning to IDLE.
module instruction_fetch
  import cpu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stall,
  input  logic                       jump,
  input  logic                       Jal_swit,
  input  logic                       JR_swit,
  input  logic [31:0]                JT,
  input  logic                       branch_taken,
  input  logic [31:0]                branch_target,
  instruction_fetch_if.master        imem,
  output logic [31:0]                PC,
  output logic [31:0]                IR,
  output logic [1:0]                 curr_state,
  output logic                       flush,
  output logic                       done
);

  fetch_state_t state, state_n;
  logic [31:0]  pc_reg, pc_n;
  logic [31:0]  pc_out, pc_out_n;
  logic [31:0]  ir, ir_n;
  logic [2:0]   drain_cnt, drain_n;
  logic         flush_n, done_n;
  logic         redirect;
  logic         is_halt;

  assign redirect = jump | Jal_swit | JR_swit;
  assign is_halt  = (imem.imem_rdata[31:26] == HALT_OPCODE);

  always_comb begin
    state_n  = state;
    pc_n     = pc_reg;
    pc_out_n = pc_out;
    ir_n     = ir;
    drain_n  = drain_cnt;
    flush_n  = 1'b0;
    done_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        ir_n = NOP;
        if (start) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (branch_taken) begin
          pc_n     = word_align(branch_target);
          ir_n     = NOP;
          pc_out_n = 32'h0;
          flush_n  = 1'b1;
        end else if (redirect) begin
          pc_n = word_align(JT);
          ir_n = NOP;
        end else if (!stall) begin
          if (is_halt) begin
            ir_n    = NOP;
            state_n = ST_HALT;
            drain_n = DRAIN_CYCLES;
          end else begin
            ir_n     = imem.imem_rdata;
            pc_n     = pc_reg + 32'd4;
            pc_out_n = pc_reg + 32'd4;
          end
        end
      end
      ST_HALT: begin
        // A late redirect means the halt was on a wrong path: resume fetching.
        if (branch_taken) begin
          pc_n     = word_align(branch_target);
          ir_n     = NOP;
          pc_out_n = 32'h0;
          flush_n  = 1'b1;
          state_n  = ST_RUN;
          drain_n  = 3'd0;
        end else if (redirect) begin
          pc_n    = word_align(JT);
          ir_n    = NOP;
          state_n = ST_RUN;
          drain_n = 3'd0;
        end else begin
          drain_n = drain_cnt - 3'd1;
          if (drain_cnt == 3'd1) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc_reg    <= RESET_PC;
      pc_out    <= 32'h0;
      ir        <= NOP;
      drain_cnt <= 3'd0;
      flush     <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      pc_reg    <= pc_n;
      pc_out    <= pc_out_n;
      ir        <= ir_n;
      drain_cnt <= drain_n;
      flush     <= flush_n;
      done      <= done_n;
    end
  end

  assign imem.imem_addr = pc_reg;
  assign PC             = pc_out;
  assign IR             = ir;
  assign curr_state     = state;

endmodule
